// File: rtl/mii_tx_framer.sv
// Byte stream to MII nibbles: preamble, SFD, payload, zero pad, CRC-32 FCS, then IFG. One nibble per cycle.
// Outputs are registered, so o_tx_en rises one cycle after i_valid in IDLE; a missing byte at an o_ready slot aborts the frame.
module mii_tx_framer #(
    parameter int PRE_NIBBLES = 15,
    parameter int MIN_LEN     = 60,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [3:0] o_data,
    output logic       o_tx_en,
    output logic       o_busy,
    output logic       o_underrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG
    } state_t;

    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
    localparam logic [7:0]  PRE_LAST  = 8'(PRE_NIBBLES - 1);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_NIBBLES - 1);

    state_t      r_state;
    logic [7:0]  r_byte;
    logic        r_last;
    logic        r_phase;
    logic [10:0] r_byte_cnt;
    logic [7:0]  r_cnt;
    logic [31:0] r_crc;
    logic [3:0]  r_data;
    logic        r_tx_en;
    logic        r_underrun;

    logic [31:0] w_crc_next;
    logic [10:0] w_cnt_inc;

    // Four LSB-first steps of the reflected CRC-32 over one nibble.
    function automatic logic [31:0] f_crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 4; i++) begin
            x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    assign w_crc_next = f_crc_nib(r_crc, r_data);
    assign w_cnt_inc  = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;

    assign o_ready    = (r_state == S_SFD) || (r_state == S_DROP) ||
                        ((r_state == S_DATA) && r_phase && !r_last);
    assign o_busy     = (r_state != S_IDLE);
    assign o_data     = r_data;
    assign o_tx_en    = r_tx_en;
    assign o_underrun = r_underrun;

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state    <= S_IDLE;
            r_byte     <= 8'h00;
            r_last     <= 1'b0;
            r_phase    <= 1'b0;
            r_byte_cnt <= 11'd0;
            r_cnt      <= 8'd0;
            r_crc      <= 32'hFFFFFFFF;
            r_data     <= 4'h0;
            r_tx_en    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_state <= S_PRE;
                        r_tx_en <= 1'b1;
                        r_data  <= 4'h5;
                        r_cnt   <= 8'd0;
                    end
                end
                S_PRE: begin
                    if (r_cnt == PRE_LAST) begin
                        r_state <= S_SFD;
                        r_data  <= 4'hD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SFD: begin
                    if (i_valid) begin
                        r_state    <= S_DATA;
                        r_byte     <= i_data;
                        r_last     <= i_last;
                        r_byte_cnt <= w_cnt_inc;
                        r_phase    <= 1'b0;
                        r_data     <= i_data[3:0];
                    end else begin
                        r_state    <= S_DROP;
                        r_tx_en    <= 1'b0;
                        r_data     <= 4'h0;
                        r_underrun <= 1'b1;
                    end
                end
                S_DATA: begin
                    r_crc <= w_crc_next;
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_data  <= r_byte[7:4];
                    end else if (!r_last) begin
                        if (i_valid) begin
                            r_byte     <= i_data;
                            r_last     <= i_last;
                            r_byte_cnt <= w_cnt_inc;
                            r_phase    <= 1'b0;
                            r_data     <= i_data[3:0];
                        end else begin
                            r_state    <= S_DROP;
                            r_tx_en    <= 1'b0;
                            r_data     <= 4'h0;
                            r_underrun <= 1'b1;
                        end
                    end else if (r_byte_cnt < MIN_LEN_C) begin
                        r_state <= S_PAD;
                        r_phase <= 1'b0;
                        r_data  <= 4'h0;
                    end else begin
                        // First FCS nibble must already include the nibble leaving now.
                        r_state <= S_FCS;
                        r_data  <= ~w_crc_next[3:0];
                        r_crc   <= w_crc_next >> 4;
                        r_cnt   <= 8'd0;
                    end
                end
                S_PAD: begin
                    r_crc   <= w_crc_next;
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_byte_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= MIN_LEN_C) begin
                            r_state <= S_FCS;
                            r_data  <= ~w_crc_next[3:0];
                            r_crc   <= w_crc_next >> 4;
                            r_cnt   <= 8'd0;
                        end
                    end
                end
                S_FCS: begin
                    if (r_cnt == 8'd7) begin
                        r_state <= S_IFG;
                        r_tx_en <= 1'b0;
                        r_data  <= 4'h0;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_data <= ~r_crc[3:0];
                        r_crc  <= r_crc >> 4;
                    end
                end
                S_DROP: begin
                    if (i_valid && i_last) begin
                        r_state <= S_IFG;
                        r_cnt   <= 8'd0;
                    end
                end
                S_IFG: begin
                    if (r_cnt == IFG_LAST) begin
                        r_state    <= S_IDLE;
                        r_crc      <= 32'hFFFFFFFF;
                        r_byte_cnt <= 11'd0;
                        r_cnt      <= 8'd0;
                        r_phase    <= 1'b0;
                        r_last     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
